bcd_to_bin_seq: RTL
===================

# bcd_to_bin_seq

Sequential BCD-to-binary converter: takes a three-digit packed BCD value (hundreds, tens, ones) and produces its 10-bit binary equivalent using iterative reverse double-dabble (shift right, subtract 3 from any digit ≥ 8). It is the inverse of the binary-to-BCD path feeding the score/level HEX displays. It converts user- or memory-supplied decimal values (e.g. a high score stored as BCD) back into binary for comparison and arithmetic. It runs as a start/busy/done multi-cycle unit to keep the per-cycle logic to three 4-bit adjusters.

## Interface

- BIN_W, 10, binary result width; also the iteration count; must be ≥ 10.
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- hundreds  input  4  BCD hundreds digit; latched on accepted start.
- tens  input  4  BCD tens digit; latched on accepted start.
- ones  input  4  BCD ones digit; latched on accepted start.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse when the result is valid.
- error  output  1  result flag; high if any latched digit was > 9; held with binary.
- binary  output  BIN_W  converted value; held until the next done.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: when start=1, load shift register sr = {hundreds, tens, ones, BIN_W'b0}, clear iteration counter, capture err_q = (any digit > 9), go to SHIFT. When start=0, stay in IDLE.
- SHIFT: each cycle, logical right shift of the full (12+BIN_W)-bit sr by one. Then, on the three BCD digit fields of the shifted value, replace each digit d ≥ 8 with d − 3 (4-bit). Increment the counter. After the BIN_W-th iteration, go to DONE.
- DONE: for one cycle, done=1. Then return to IDLE.
- On the edge entering DONE: binary ← err_q ? 0 : sr[BIN_W-1:0], and error ← err_q. Both hold until the next entry to DONE.
- Invalid digits do not shorten the conversion: the iterations still run, so latency is fixed.
- start is ignored in SHIFT and DONE; there is no queueing. A start asserted in DONE is not accepted; it must be present in IDLE.
- Inputs are sampled only on the accepting edge. Changes during SHIFT have no effect.
- Result range: 0–999; BIN_W=10 covers it with no overflow. For BIN_W > 10 the upper bits are zero.

## Timing

- Reset (async assert, sync release): state=IDLE, busy=0, done=0, error=0, binary=0, sr=0, counter=0.
- Reset mid-conversion aborts immediately to the reset values. The partial result is discarded, and no done pulse is issued.
- start accepted at edge k. busy=1 from edge k to edge k+BIN_W. Edge k+BIN_W enters DONE and updates binary/error; done=1 from edge k+BIN_W to k+BIN_W+1.
- Latency: BIN_W cycles from the accepting edge to done (10 cycles by default).
- Back-to-back throughput: the earliest next acceptance is edge k+BIN_W+2 (start held high continuously gives one conversion per BIN_W+2 cycles).
- busy and done are never high together. done is registered, not combinational.

## Structure

- Shared package bcd_pkg: state enum (IDLE, SHIFT, DONE), BCD_DIGITS=3, DIGIT_W=4, BCD_MAX_DIGIT=9.
- Sub-module bcd_digit_adj: combinational 4-bit "if d ≥ 8 then d − 3". Instantiated three times on the shifted digit fields.
- Top: FSM, iteration counter of width $clog2(BIN_W+1), shift register, output registers.

## Test plan

- Reset, then hundreds=9, tens=9, ones=9 with a one-cycle start → busy for 10 cycles; single done pulse; binary=999 (10'h3E7); error=0.
- Digits 0,0,0 → binary=0, error=0. Digits 2,5,5 → binary=255 (10'h0FF). Digits 1,0,0 → binary=100 (10'h064).
- tens=4'hA, others 0 → same 10-cycle latency; done pulse; error=1, binary=0. A following valid start with digits 0,4,2 → error=0, binary=42.
- Start pulses during SHIFT, with different digits, are ignored: the first conversion's result is unchanged, and exactly one done pulse is produced.
- reset_n low for 2 cycles in the 5th SHIFT cycle → busy, done, error and binary are 0 immediately. After release, a new start with digits 3,1,4 → binary=314 after 10 cycles.
- Sweep: all 1000 valid inputs, with start held high → each result equals 100·h+10·t+o; done spacing of exactly 12 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the FSM state encoding, digit geometry and a digit-validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_DIGITS    = 3;
  localparam int          DIGIT_W       = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a shifted BCD digit of 8 or more
// had a borrow-in of ten from the digit above, so it is pulled back by 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative three-digit BCD to binary converter (reverse double-dabble),
// one shift/correct step per cycle, BIN_W steps per conversion.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [BIN_W-1:0] binary,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only in IDLE, which latches the digits.
  // busy stays high for exactly BIN_W cycles, then done pulses for one cycle
  // with binary/error valid; they hold until the next done. No queueing.

  localparam int SR_W  = BCD_DIGITS * DIGIT_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [BIN_W-1:0] binary_q, binary_d;
  logic             error_q, error_d;

  logic [SR_W-1:0]    sr_shift;
  logic [SR_W-1:0]    sr_adj;
  logic [DIGIT_W-1:0] adj [BCD_DIGITS];

  assign sr_shift = sr_q >> 1;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sr_shift[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .q (adj[g])
    );
  end

  always_comb begin
    sr_adj = sr_shift;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      sr_adj[BIN_W + i*DIGIT_W +: DIGIT_W] = adj[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    binary_d = binary_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {hundreds, tens, ones, {BIN_W{1'b0}}};
          cnt_d   = '0;
          err_d   = digit_invalid(hundreds) | digit_invalid(tens) | digit_invalid(ones);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + CNT_W'(1);
        // The final step's result goes straight to the output register.
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          binary_d = err_q ? '0 : sr_adj[BIN_W-1:0];
          error_d  = err_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      binary_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      binary_q <= binary_d;
      error_q  <= error_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign error     = error_q;
  assign binary    = binary_q;
  assign dbg_state = state_q;

endmodule
